// File: rtl/timer_scheduler_pkg.sv
// rtl/timer_scheduler_pkg.sv - register offsets, scan FSM state type and wrap-aware deadline helpers
package timer_scheduler_pkg;

    localparam logic [31:0] SLOT_BASE_DEFAULT = 32'hffff0080;
    localparam logic [31:0] CTRL_BASE_DEFAULT = 32'hffff00a0;

    localparam logic [31:0] OFF_PENDING = 32'h0000_0000;
    localparam logic [31:0] OFF_ACK     = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
    localparam logic [31:0] OFF_CANCEL  = 32'h0000_000c;
    localparam logic [31:0] OFF_PERIOD  = 32'h0000_0020;

    typedef enum logic [1:0] {IDLE, SCAN, ARMED} sched_state_t;

    // Signed distance keeps ordering correct across counter wrap within 2^31 cycles.
    function automatic logic signed [31:0] deadline_distance(input logic [31:0] deadline,
                                                             input logic [31:0] now);
        return $signed(deadline - now);
    endfunction

    function automatic logic deadline_due(input logic [31:0] deadline, input logic [31:0] now);
        return deadline_distance(deadline, now) <= 0;
    endfunction

endpackage

// File: rtl/timer_scheduler_sched_slot.sv
// rtl/timer_scheduler_sched_slot.sv - one deadline slot; TIMER_SCHED_PERIODIC_EN adds a reload period
module sched_slot (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr,
    input  logic        cancel,
    input  logic        ack,
    input  logic        fire,
    input  logic [31:0] wdata,
`ifdef TIMER_SCHED_PERIODIC_EN
    input  logic        period_wr,
    output logic [31:0] period,
`endif
    output logic [31:0] deadline,
    output logic        valid,
    output logic        pending
);

    // Write beats cancel beats fire; a fire suppressed by write or cancel never raises pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deadline <= '0;
            valid    <= 1'b0;
        end else if (wr) begin
            deadline <= wdata;
            valid    <= 1'b1;
        end else if (cancel) begin
            valid    <= 1'b0;
        end else if (fire) begin
`ifdef TIMER_SCHED_PERIODIC_EN
            if (period != '0) begin
                deadline <= deadline + period;
            end else begin
                valid    <= 1'b0;
            end
`else
            valid    <= 1'b0;
`endif
        end
    end

    // A fire in the same cycle as an ack leaves the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (fire && !wr && !cancel) begin
            pending <= 1'b1;
        end else if (ack) begin
            pending <= 1'b0;
        end
    end

`ifdef TIMER_SCHED_PERIODIC_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period <= '0;
        end else if (period_wr) begin
            period <= wdata;
        end
    end
`endif

endmodule

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - multiplexes one cycle counter among SLOTS deadlines; TIMER_SCHED_PERIODIC_EN enables periodic slots
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int          SLOTS = 4,
    parameter logic [31:0] BASE  = SLOT_BASE_DEFAULT,
    parameter logic [31:0] CTRL  = CTRL_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        SchedAddress,
    output logic        TimerInterrupt,
    output logic [31:0] cycle
);

    sched_state_t       state;
    logic [2:0]         scan_idx;
    logic [2:0]         best_idx;
    logic               best_found;
    logic signed [31:0] best_dist;

    logic [31:0]      deadline [SLOTS];
    logic [SLOTS-1:0] valid, pending;
    logic [SLOTS-1:0] hit_slot, slot_wr, ack_vec, cancel_vec, fire_vec;
    logic             hit_pending, hit_ack, hit_status, hit_cancel, cancel_any;
    logic             fire, restart, cand_valid, cand_better, best_valid;
    logic [31:0]      cand_deadline, best_deadline, status_word;
    logic signed [31:0] cand_dist;
    logic             unused_read;

`ifdef TIMER_SCHED_PERIODIC_EN
    logic [31:0]      period [SLOTS];
    logic [SLOTS-1:0] hit_period, period_wr;
`endif

    assign unused_read = MemRead;

    always_comb begin
        hit_slot = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit_slot[i] = (address == BASE + 32'(4 * i));
        end
        hit_pending = (address == CTRL + OFF_PENDING);
        hit_ack     = (address == CTRL + OFF_ACK);
        hit_status  = (address == CTRL + OFF_STATUS);
        hit_cancel  = (address == CTRL + OFF_CANCEL);
        SchedAddress = (|hit_slot) | hit_pending | hit_ack | hit_status | hit_cancel;
`ifdef TIMER_SCHED_PERIODIC_EN
        hit_period = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit_period[i] = (address == CTRL + OFF_PERIOD + 32'(4 * i));
        end
        SchedAddress = SchedAddress | (|hit_period);
        period_wr    = MemWrite ? hit_period : '0;
`endif
        slot_wr    = MemWrite ? hit_slot : '0;
        cancel_any = MemWrite && hit_cancel;
        ack_vec    = (MemWrite && hit_ack) ? data[SLOTS-1:0] : '0;
        cancel_vec = cancel_any ? data[SLOTS-1:0] : '0;
    end

    // Select the slot under scan and the armed slot without narrowing the index.
    always_comb begin
        cand_deadline = '0;
        cand_valid    = 1'b0;
        best_deadline = '0;
        best_valid    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (scan_idx == 3'(i)) begin
                cand_deadline = deadline[i];
                cand_valid    = valid[i];
            end
            if (best_idx == 3'(i)) begin
                best_deadline = deadline[i];
                best_valid    = valid[i];
            end
        end
    end

    // Distances are taken against the cycle at scan start so all slots share one reference.
    assign cand_dist   = deadline_distance(cand_deadline, cycle - 32'(scan_idx));
    assign cand_better = cand_valid && (!best_found || (cand_dist < best_dist));
    assign fire        = (state == ARMED) && best_valid && deadline_due(best_deadline, cycle);
    assign restart     = (|slot_wr) || cancel_any || fire;

    always_comb begin
        fire_vec = '0;
        for (int i = 0; i < SLOTS; i++) begin
            fire_vec[i] = fire && (best_idx == 3'(i));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_found <= 1'b0;
            best_dist  <= '0;
            cycle      <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (restart) begin
                state      <= SCAN;
                scan_idx   <= '0;
                best_idx   <= '0;
                best_found <= 1'b0;
                best_dist  <= '0;
            end else begin
                case (state)
                    SCAN: begin
                        if (cand_better) begin
                            best_idx   <= scan_idx;
                            best_found <= 1'b1;
                            best_dist  <= cand_dist;
                        end
                        if (scan_idx == 3'(SLOTS - 1)) begin
                            state    <= (best_found || cand_better) ? ARMED : IDLE;
                            scan_idx <= '0;
                        end else begin
                            scan_idx <= scan_idx + 3'd1;
                        end
                    end
                    IDLE, ARMED: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sched_slot u_slot (
            .clock    (clock),
            .reset    (reset),
            .wr       (slot_wr[g]),
            .cancel   (cancel_vec[g]),
            .ack      (ack_vec[g]),
            .fire     (fire_vec[g]),
            .wdata    (data),
`ifdef TIMER_SCHED_PERIODIC_EN
            .period_wr(period_wr[g]),
            .period   (period[g]),
`endif
            .deadline (deadline[g]),
            .valid    (valid[g]),
            .pending  (pending[g])
        );
    end

    assign TimerInterrupt = |pending;

    always_comb begin
        status_word              = '0;
        status_word[8 +: SLOTS]  = valid;
        status_word[7]           = (state == ARMED);
        status_word[2:0]         = best_idx;
        rdata = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (hit_slot[i]) rdata = deadline[i];
        end
`ifdef TIMER_SCHED_PERIODIC_EN
        for (int i = 0; i < SLOTS; i++) begin
            if (hit_period[i]) rdata = period[i];
        end
`endif
        if (hit_pending) rdata = 32'(pending);
        if (hit_status)  rdata = status_word;
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed self-checking bench for timer_scheduler; TIMER_SCHED_PERIODIC_EN adds the periodic scenario
module tb_timer_scheduler;

    localparam logic [31:0] A_SLOT0  = 32'hffff0080;
    localparam logic [31:0] A_SLOT1  = 32'hffff0084;
    localparam logic [31:0] A_SLOT2  = 32'hffff0088;
    localparam logic [31:0] A_SLOT3  = 32'hffff008c;
    localparam logic [31:0] A_PEND   = 32'hffff00a0;
    localparam logic [31:0] A_ACK    = 32'hffff00a4;
    localparam logic [31:0] A_STAT   = 32'hffff00a8;
    localparam logic [31:0] A_CANCEL = 32'hffff00ac;
    localparam logic [31:0] A_HOLE   = 32'hffff00b0;
    localparam logic [31:0] A_PER0   = 32'hffff00c0;
`ifdef TIMER_SCHED_PERIODIC_EN
    localparam logic EXP_PER_HIT = 1'b1;
`else
    localparam logic EXP_PER_HIT = 1'b0;
`endif

    logic        clock, reset, MemRead, MemWrite, SchedAddress, TimerInterrupt;
    logic [31:0] address, data, rdata, cycle, rd;
    int          checks, errors;

    timer_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .data          (data),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .rdata         (rdata),
        .SchedAddress  (SchedAddress),
        .TimerInterrupt(TimerInterrupt),
        .cycle         (cycle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a; data = d; MemWrite = 1'b1;
        @(posedge clock); #1;
        MemWrite = 1'b0;
        @(negedge clock);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a; MemRead = 1'b1; #1;
        d = rdata; MemRead = 1'b0;
    endtask

    task automatic wait_cycle(input logic [31:0] target);
        int n = 0;
        while (cycle !== target && n < 4000) begin @(negedge clock); n++; end
        if (cycle !== target) begin
            checks++; errors++;
            $display("FAIL wait_cycle actual %0d required %0d", cycle, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (cycle !== 32'd0) begin errors++; $display("FAIL reset_cycle actual %h required 0", cycle); end
        checks++; if (TimerInterrupt !== 1'b0) begin errors++; $display("FAIL reset_irq actual %b required 0", TimerInterrupt); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status actual %h required 0", rd); end
        checks++; if (SchedAddress !== 1'b1) begin errors++; $display("FAIL decode_status actual %b required 1", SchedAddress); end
        bus_read(A_HOLE, rd);
        checks++; if (SchedAddress !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL decode_hole actual %b/%h required 0/0", SchedAddress, rd); end
        bus_read(A_PER0, rd);
        checks++; if (SchedAddress !== EXP_PER_HIT) begin errors++; $display("FAIL decode_period actual %b required %b", SchedAddress, EXP_PER_HIT); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single();
        wait_cycle(32'd5);
        bus_write(A_SLOT1, 32'd20);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h200) begin errors++; $display("FAIL single_scan_status actual %h required 200", rd); end
        wait_cycle(32'd10);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h281) begin errors++; $display("FAIL single_armed_status actual %h required 281", rd); end
        wait_cycle(32'd20);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0 || TimerInterrupt !== 1'b0) begin errors++; $display("FAIL single_early actual %h/%b required 0/0", rd, TimerInterrupt); end
        wait_cycle(32'd21);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h2 || TimerInterrupt !== 1'b1) begin errors++; $display("FAIL single_fire actual %h/%b required 2/1", rd, TimerInterrupt); end
        bus_read(A_SLOT1, rd);
        checks++; if (rd !== 32'd20) begin errors++; $display("FAIL single_readback actual %h required 14", rd); end
        wait_cycle(32'd26);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL single_idle actual %h required 0", rd); end
        bus_write(A_ACK, 32'h2);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0 || TimerInterrupt !== 1'b0) begin errors++; $display("FAIL single_ack actual %h/%b required 0/0", rd, TimerInterrupt); end
    endtask

    task automatic test_tie();
        wait_cycle(32'd30);
        bus_write(A_SLOT0, 32'd200);
        bus_write(A_SLOT2, 32'd120);
        bus_write(A_SLOT3, 32'd120);
        wait_cycle(32'd40);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'hd82) begin errors++; $display("FAIL tie_best actual %h required d82", rd); end
        wait_cycle(32'd120);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tie_early actual %h required 0", rd); end
        wait_cycle(32'd121);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL tie_first actual %h required 4", rd); end
        wait_cycle(32'd125);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL tie_rescan actual %h required 4", rd); end
        wait_cycle(32'd126);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'hc) begin errors++; $display("FAIL tie_second actual %h required c", rd); end
        wait_cycle(32'd131);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h180) begin errors++; $display("FAIL tie_remaining actual %h required 180", rd); end
        bus_write(A_CANCEL, 32'h1);
        bus_write(A_ACK, 32'hf);
        wait_cycle(32'd140);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tie_cancel actual %h required 0", rd); end
    endtask

    task automatic test_past();
        wait_cycle(32'd150);
        bus_write(A_SLOT0, 32'd140);
        wait_cycle(32'd155);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL past_early actual %h required 0", rd); end
        wait_cycle(32'd156);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1 || TimerInterrupt !== 1'b1) begin errors++; $display("FAIL past_fire actual %h/%b required 1/1", rd, TimerInterrupt); end
        bus_write(A_ACK, 32'h1);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0 || TimerInterrupt !== 1'b0) begin errors++; $display("FAIL past_ack actual %h/%b required 0/0", rd, TimerInterrupt); end
    endtask

    task automatic test_wrap();
        wait_cycle(32'd160);
        bus_write(A_SLOT2, 32'h7fffffa0);
        bus_write(A_SLOT1, 32'hfffffff0);
        wait_cycle(32'd166);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h681) begin errors++; $display("FAIL wrap_best actual %h required 681", rd); end
        wait_cycle(32'd167);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL wrap_fire actual %h required 2", rd); end
        wait_cycle(32'd172);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h482) begin errors++; $display("FAIL wrap_future actual %h required 482", rd); end
        bus_write(A_CANCEL, 32'h4);
        bus_write(A_ACK, 32'h2);
        wait_cycle(32'd180);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_clear actual %h required 0", rd); end
    endtask

    task automatic test_back_to_back();
        wait_cycle(32'd190);
        bus_write(A_SLOT2, 32'd210);
        wait_cycle(32'd210);
        bus_write(A_ACK, 32'h4);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL ack_fire actual %h required 4", rd); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ack_fire_valid actual %h required 0", rd); end
        bus_write(A_ACK, 32'h4);
        wait_cycle(32'd220);
        bus_write(A_SLOT2, 32'd240);
        wait_cycle(32'd240);
        bus_write(A_SLOT2, 32'd260);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rewrite_pending actual %h required 0", rd); end
        bus_read(A_SLOT2, rd);
        checks++; if (rd !== 32'd260) begin errors++; $display("FAIL rewrite_deadline actual %h required 104", rd); end
        wait_cycle(32'd246);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h482) begin errors++; $display("FAIL rewrite_armed actual %h required 482", rd); end
        wait_cycle(32'd260);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rewrite_early actual %h required 0", rd); end
        wait_cycle(32'd261);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL rewrite_fire actual %h required 4", rd); end
        bus_write(A_ACK, 32'h4);
        wait_cycle(32'd270);
        bus_write(A_SLOT1, 32'd290);
        wait_cycle(32'd290);
        bus_write(A_CANCEL, 32'h2);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cancel_fire actual %h required 0", rd); end
        wait_cycle(32'd300);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cancel_idle actual %h required 0", rd); end
    endtask

    task automatic test_reset_mid_scan();
        wait_cycle(32'd310);
        bus_write(A_SLOT0, 32'd5000);
        bus_write(A_SLOT1, 32'd5000);
        bus_write(A_SLOT2, 32'd5000);
        reset = 1'b0;
        #1;
        checks++; if (cycle !== 32'd0 || TimerInterrupt !== 1'b0) begin errors++; $display("FAIL midreset_outputs actual %h/%b required 0/0", cycle, TimerInterrupt); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_status actual %h required 0", rd); end
        bus_read(A_SLOT0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_deadline actual %h required 0", rd); end
        @(negedge clock);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0 || cycle !== 32'd0) begin errors++; $display("FAIL midreset_hold actual %h/%h required 0/0", rd, cycle); end
        reset = 1'b1;
    endtask

`ifdef TIMER_SCHED_PERIODIC_EN
    task automatic test_periodic();
        bus_write(A_PER0, 32'd10);
        bus_write(A_SLOT0, 32'd30);
        bus_read(A_PER0, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL periodic_reg actual %h required a", rd); end
        wait_cycle(32'd31);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL periodic_fire30 actual %h required 1", rd); end
        bus_read(A_SLOT0, rd);
        checks++; if (rd !== 32'd40) begin errors++; $display("FAIL periodic_reload actual %h required 28", rd); end
        bus_write(A_ACK, 32'h1);
        wait_cycle(32'd40);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL periodic_early40 actual %h required 0", rd); end
        wait_cycle(32'd41);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL periodic_fire40 actual %h required 1", rd); end
        bus_write(A_ACK, 32'h1);
        wait_cycle(32'd51);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL periodic_fire50 actual %h required 1", rd); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; address = '0; data = '0; MemRead = 1'b0; MemWrite = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_past();
        test_wrap();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef TIMER_SCHED_PERIODIC_EN
        test_periodic();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
